tlb_op_ctrl: RTL and testbench

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/tlb_op_ctrl.sv | 149 ++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: runs TLBP/TLBR/TLBWI/TLBWR from WB through the
// search, read and write ports of the TLB and the CP0 capture strobes.
module tlb_op_ctrl #(
   parameter int TLBNUM       = 16,
   parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    op_valid,
   input  logic [1:0]              op_code,
   output logic                    op_ready,
   input  logic                    kill,
   output logic                    op_done,
   output logic                    refetch_req,
   input  logic [18:0]             entry_hi_vpn2,
   input  logic [7:0]              entry_hi_asid,
   input  logic [TLBNUM_WIDTH-1:0] index_in,
   input  logic [TLBNUM_WIDTH-1:0] random_in,
   output logic                    s_valid,
   output logic [18:0]             s_vpn2,
   output logic [7:0]              s_asid,
   input  logic                    s_found,
   input  logic [TLBNUM_WIDTH-1:0] s_index,
   output logic                    r_en,
   output logic [TLBNUM_WIDTH-1:0] r_index,
   output logic                    tlbp,
   output logic [TLBNUM_WIDTH:0]   tlbp_result,
   output logic                    tlbr,
   output logic                    tlb_we,
   output logic [TLBNUM_WIDTH-1:0] w_index
);

   localparam logic [1:0] OP_TLBP  = 2'b00;
   localparam logic [1:0] OP_TLBR  = 2'b01;
   localparam logic [1:0] OP_TLBWI = 2'b10;
   localparam logic [1:0] OP_TLBWR = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SEARCH = 3'd1,
      S_PRES   = 3'd2,
      S_READ   = 3'd3,
      S_RCAP   = 3'd4,
      S_WRITE  = 3'd5,
      S_DONE   = 3'd6
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              op_q;
   logic [18:0]             vpn2_q;
   logic [7:0]              asid_q;
   logic [TLBNUM_WIDTH-1:0] index_q;
   logic [TLBNUM_WIDTH-1:0] random_q;
   logic                    accept;
   logic                    squash;

   assign accept = (state_q == S_IDLE) && op_valid && !kill;
   // A flush mid-operation and reset both abort silently: no strobe that cycle.
   assign squash = reset || (kill && (state_q != S_IDLE));

   // NOTE: every output and state_d gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      op_ready    = 1'b0;
      op_done     = 1'b0;
      refetch_req = 1'b0;
      s_valid     = 1'b0;
      s_vpn2      = '0;
      s_asid      = '0;
      r_en        = 1'b0;
      r_index     = '0;
      tlbp        = 1'b0;
      tlbp_result = '0;
      tlbr        = 1'b0;
      tlb_we      = 1'b0;
      w_index     = '0;

      if (squash) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               op_ready = 1'b1;
               if (accept) begin
                  unique case (op_code)
                     OP_TLBP:  state_d = S_SEARCH;
                     OP_TLBR:  state_d = S_READ;
                     default:  state_d = S_WRITE;
                  endcase
               end
            end
            S_SEARCH: begin
               s_valid = 1'b1;
               s_vpn2  = vpn2_q;
               s_asid  = asid_q;
               state_d = S_PRES;
            end
            S_PRES: begin
               tlbp        = 1'b1;
               // A miss reports P=1 with a clean zero index.
               tlbp_result = s_found ? {1'b0, s_index} : {1'b1, {TLBNUM_WIDTH{1'b0}}};
               state_d     = S_DONE;
            end
            S_READ: begin
               r_en    = 1'b1;
               r_index = index_q;
               state_d = S_RCAP;
            end
            S_RCAP: begin
               tlbr    = 1'b1;
               state_d = S_DONE;
            end
            S_WRITE: begin
               tlb_we  = 1'b1;
               w_index = (op_q == OP_TLBWR) ? random_q : index_q;
               state_d = S_DONE;
            end
            S_DONE: begin
               op_done     = 1'b1;
               refetch_req = (op_q != OP_TLBP);
               state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= OP_TLBP;
         vpn2_q   <= '0;
         asid_q   <= '0;
         index_q  <= '0;
         random_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q     <= op_code;
            vpn2_q   <= entry_hi_vpn2;
            asid_q   <= entry_hi_asid;
            index_q  <= index_in;
            random_q <= random_in;
         end
      end
   end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed scenarios plus randomized operations
// compared against a per-operation timeline model.
module tb_tlb_op_ctrl;

   localparam int W = 4;

   typedef struct packed {
      logic         op_ready;
      logic         s_valid;
      logic [18:0]  s_vpn2;
      logic [7:0]   s_asid;
      logic         r_en;
      logic [W-1:0] r_index;
      logic         tlbp;
      logic [W:0]   tlbp_result;
      logic         tlbr;
      logic         tlb_we;
      logic [W-1:0] w_index;
      logic         op_done;
      logic         refetch_req;
   } obs_t;

   logic         clk = 1'b0;
   logic         reset, op_valid, kill, s_found;
   logic [1:0]   op_code;
   logic [18:0]  entry_hi_vpn2;
   logic [7:0]   entry_hi_asid;
   logic [W-1:0] index_in, random_in, s_index;
   logic         op_ready, op_done, refetch_req, s_valid, r_en, tlbp, tlbr, tlb_we;
   logic [18:0]  s_vpn2;
   logic [7:0]   s_asid;
   logic [W-1:0] r_index, w_index;
   logic [W:0]   tlbp_result;
   obs_t         obs;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tlb_op_ctrl #(.TLBNUM(16), .TLBNUM_WIDTH(W)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready), .kill(kill), .op_done(op_done), .refetch_req(refetch_req),
      .entry_hi_vpn2(entry_hi_vpn2), .entry_hi_asid(entry_hi_asid),
      .index_in(index_in), .random_in(random_in),
      .s_valid(s_valid), .s_vpn2(s_vpn2), .s_asid(s_asid),
      .s_found(s_found), .s_index(s_index),
      .r_en(r_en), .r_index(r_index), .tlbp(tlbp), .tlbp_result(tlbp_result),
      .tlbr(tlbr), .tlb_we(tlb_we), .w_index(w_index)
   );

   assign obs = {op_ready, s_valid, s_vpn2, s_asid, r_en, r_index, tlbp, tlbp_result,
                 tlbr, tlb_we, w_index, op_done, refetch_req};

   // Expected outputs k cycles after the accept cycle, straight from the op timelines.
   function automatic obs_t model_out(input logic [1:0] op, input int k, input logic squash,
                                      input logic [18:0] vpn2, input logic [7:0] asid,
                                      input logic [W-1:0] idx, input logic [W-1:0] rnd,
                                      input logic found, input logic [W-1:0] sidx);
      obs_t e = '0;
      if (k == 0) begin
         e.op_ready = 1'b1;
      end else if (!squash) begin
         if (op == 2'b00) begin
            if (k == 1) begin
               e.s_valid = 1'b1;
               e.s_vpn2  = vpn2;
               e.s_asid  = asid;
            end else if (k == 2) begin
               e.tlbp        = 1'b1;
               e.tlbp_result = found ? {1'b0, sidx} : {1'b1, {W{1'b0}}};
            end else if (k == 3) begin
               e.op_done = 1'b1;
            end
         end else if (op == 2'b01) begin
            if (k == 1) begin
               e.r_en    = 1'b1;
               e.r_index = idx;
            end else if (k == 2) begin
               e.tlbr = 1'b1;
            end else if (k == 3) begin
               e.op_done     = 1'b1;
               e.refetch_req = 1'b1;
            end
         end else begin
            if (k == 1) begin
               e.tlb_we  = 1'b1;
               e.w_index = (op == 2'b11) ? rnd : idx;
            end else if (k == 2) begin
               e.op_done     = 1'b1;
               e.refetch_req = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic scramble_inputs();
      op_valid      = 1'($urandom);
      op_code       = 2'($urandom);
      entry_hi_vpn2 = 19'($urandom);
      entry_hi_asid = 8'($urandom);
      index_in      = W'($urandom);
      random_in     = W'($urandom);
      s_found       = 1'($urandom);
      s_index       = W'($urandom);
   endtask

   // One operation from its accept cycle to op_done, or to an injected kill/reset.
   task automatic do_op(input string name, input logic [1:0] op, input logic [18:0] vpn2,
                        input logic [7:0] asid, input logic [W-1:0] idx, input logic [W-1:0] rnd,
                        input logic found, input logic [W-1:0] sidx,
                        input int kill_at, input int reset_at);
      int   lat;
      logic sq;
      obs_t e;
      lat = op[1] ? 2 : 3;
      @(negedge clk);
      scramble_inputs();
      reset = 1'b0; kill = 1'b0; op_valid = 1'b1; op_code = op;
      entry_hi_vpn2 = vpn2; entry_hi_asid = asid; index_in = idx; random_in = rnd;
      #1;
      e = model_out(op, 0, 1'b0, vpn2, asid, idx, rnd, found, sidx);
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL %s accept op=%0d got=%h exp=%h", name, op, obs, e);
      end
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         scramble_inputs();
         if (k == 2) begin
            s_found = found;
            s_index = sidx;
         end
         kill  = (k == kill_at);
         reset = (k == reset_at);
         sq    = kill || reset;
         #1;
         e = model_out(op, k, sq, vpn2, asid, idx, rnd, found, sidx);
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL %s k=%0d op=%0d got=%h exp=%h", name, k, op, obs, e);
         end
         if (sq) break;
      end
   endtask

   task automatic idle_cycle(input string name, input logic try_kill);
      obs_t e;
      @(negedge clk);
      scramble_inputs();
      reset = 1'b0; kill = try_kill; op_valid = try_kill;
      #1;
      e = '0;
      e.op_ready = 1'b1;
      total++;
      if (obs !== e) begin
         bad++;
         $display("FAIL %s idle got=%h exp=%h", name, obs, e);
      end
   endtask

   task automatic test_reset();
      obs_t o;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         scramble_inputs();
         kill = 1'($urandom);
         #1;
         o = obs;
         o.op_ready = 1'b0;
         total++;
         if (o !== '0) begin
            bad++;
            $display("FAIL reset cyc=%0d got=%h exp=0", i, o);
         end
      end
   endtask

   task automatic test_tlbp();
      do_op("tlbp_hit", 2'b00, 19'h12345, 8'h5A, 4'd2, 4'd5, 1'b1, 4'd7, 0, 0);
      do_op("tlbp_miss", 2'b00, 19'h0ABCD, 8'h11, 4'd1, 4'd6, 1'b0, 4'd9, 0, 0);
   endtask

   task automatic test_tlbwr();
      do_op("tlbwr", 2'b11, 19'h00001, 8'h01, 4'd4, 4'd9, 1'b0, 4'd0, 0, 0);
   endtask

   task automatic test_tlbr();
      do_op("tlbr", 2'b01, 19'h7FFFF, 8'hFF, 4'd3, 4'd12, 1'b1, 4'd1, 0, 0);
   endtask

   task automatic test_kill();
      do_op("kill_read", 2'b01, 19'h2AAAA, 8'h33, 4'd3, 4'd8, 1'b1, 4'd2, 1, 0);
      do_op("after_kill", 2'b10, 19'h15555, 8'h44, 4'd11, 4'd1, 1'b0, 4'd0, 0, 0);
      idle_cycle("kill_idle", 1'b1);
      idle_cycle("kill_idle_after", 1'b0);
   endtask

   task automatic test_back_to_back();
      do_op("reset_search", 2'b00, 19'h13579, 8'h77, 4'd5, 4'd5, 1'b1, 4'd5, 0, 1);
      for (int i = 0; i < 4; i++)
         do_op("b2b_tlbwi", 2'b10, 19'($urandom), 8'($urandom), W'(i * 5 + 1), W'($urandom),
               1'b0, 4'd0, 0, 0);
   endtask

   task automatic test_random();
      logic [1:0] op;
      int         lat, ka, ra;
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 2)) idle_cycle("rand_idle", 1'($urandom));
         op  = 2'($urandom);
         lat = op[1] ? 2 : 3;
         ka  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat)) : 0;
         ra  = (ka == 0 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, lat)) : 0;
         do_op("random", op, 19'($urandom), 8'($urandom), W'($urandom), W'($urandom),
               1'($urandom), W'($urandom), ka, ra);
      end
   endtask

   initial begin
      reset = 1'b1; kill = 1'b0; op_valid = 1'b0; op_code = 2'b00;
      entry_hi_vpn2 = '0; entry_hi_asid = '0; index_in = '0; random_in = '0;
      s_found = 1'b0; s_index = '0;
      test_reset();
      test_tlbp();
      test_tlbwr();
      test_tlbr();
      test_kill();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
